// File: rtl/phase_shift_gen.sv
// Two equal-frequency square waves; shift_out trails ref_out by a run-time
// adjustable number of clk cycles, stepped by two debounced pushbuttons.
// The offset is only applied at the period wrap so neither output can glitch.
module phase_shift_gen #(
  parameter int HALF_PERIOD     = 60,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_btn_n,
  input  logic             dec_btn_n,
  output logic             ref_out,
  output logic             shift_out,
  output logic [CNT_W-1:0] phase
);

  localparam int NUM_BTN = 2;   // bit 0 = inc, bit 1 = dec
  localparam int P       = 2 * HALF_PERIOD;
  localparam int LOCK_W  = $clog2(DEBOUNCE_CYCLES + 1);

  // One extra bit so cnt + P never overflows before the wrap correction.
  localparam logic [CNT_W:0]       P_X       = (CNT_W+1)'(P);
  localparam logic [CNT_W:0]       STEP_X    = (CNT_W+1)'(STEP);
  localparam logic [CNT_W:0]       HALF_X    = (CNT_W+1)'(HALF_PERIOD);
  localparam logic [CNT_W-1:0]     LAST      = CNT_W'(P - 1);
  localparam logic [LOCK_W-1:0]    LOCK_LOAD = LOCK_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phase_next;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync1, sync2, hist;
  logic [NUM_BTN-1:0] accept;
  logic [NUM_BTN-1:0][LOCK_W-1:0] lock;

  logic [CNT_W:0] cnt_x, ph_x, pn_x;
  logic [CNT_W:0] pos;
  logic [CNT_W:0] pn_inc, pn_dec;

  assign btn_raw = {dec_btn_n, inc_btn_n};
  assign cnt_x   = {1'b0, cnt};
  assign ph_x    = {1'b0, phase};
  assign pn_x    = {1'b0, phase_next};

  // Falling edge on the synchronized pin, gated by that button's lockout.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTN; i++)
      accept[i] = hist[i] & ~sync2[i] & (lock[i] == '0);
  end

  // Position within the shifted period: (cnt - phase) mod P, unsigned.
  always_comb begin
    pos = '0;
    if (cnt_x >= ph_x) pos = cnt_x - ph_x;
    else               pos = cnt_x + P_X - ph_x;
  end

  // Next pending offset for a single step up or down, wrapped explicitly.
  always_comb begin
    pn_inc = '0;
    pn_dec = '0;
    if (pn_x >= P_X - STEP_X) pn_inc = pn_x - (P_X - STEP_X);
    else                      pn_inc = pn_x + STEP_X;
    if (pn_x >= STEP_X)       pn_dec = pn_x - STEP_X;
    else                      pn_dec = pn_x + (P_X - STEP_X);
  end

  // Button synchronizers, edge history and per-button lockout counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      hist  <= '1;
      lock  <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      hist  <= sync2;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (accept[i])          lock[i] <= LOCK_LOAD;
        else if (lock[i] != '0) lock[i] <= lock[i] - 1'b1;
      end
    end
  end

  // Period counter, both waves, pending offset and wrap-aligned apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      phase      <= '0;
      phase_next <= '0;
      ref_out    <= 1'b0;
      shift_out  <= 1'b0;
    end else begin
      cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
      ref_out   <= (cnt_x < HALF_X);
      shift_out <= (pos < HALF_X);
      // Simultaneous inc and dec cancel; both lockouts still load above.
      if (accept[0] && !accept[1])      phase_next <= pn_inc[CNT_W-1:0];
      else if (accept[1] && !accept[0]) phase_next <= pn_dec[CNT_W-1:0];
      if (cnt == LAST) phase <= phase_next;
    end
  end

endmodule

// File: doc/phase_shift_gen.md
Name: phase_shift_gen

Overview:
- Generates two equal-frequency square waves, ref_out and shift_out, for driving a sampling/synchronizer test setup.
- The phase offset of shift_out relative to ref_out is adjusted at run time by two raw pushbuttons.
- All logic runs on a single clock. The block sources the stimulus that the metastability test path consumes.

Parameters:
- HALF_PERIOD, 60: half period of both waves in clk cycles. Period P = 2*HALF_PERIOD; 12 MHz clk gives 100 kHz. Must be >= 2.
- STEP, 1: phase change per accepted button press, in clk cycles. Must satisfy 1 <= STEP < P.
- DEBOUNCE_CYCLES, 120000: lockout after an accepted press, in clk cycles (10 ms at 12 MHz). Must be >= 1.
- CNT_W, 7: width of the period counter and phase, equal to ceil(log2(P)).

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- inc_btn_n  in  1  raw async button, active-low; each press advances the phase
- dec_btn_n  in  1  raw async button, active-low; each press retards the phase
- ref_out  out  1  reference square wave, registered
- shift_out  out  1  phase-shifted square wave, registered
- phase  out  CNT_W  applied offset in clk cycles, 0..P-1, registered

Behaviour:
- Reset is synchronous and active-high, on port rst; clock is clk.
- Reset values:
  - cnt=0, phase=0, phase_next=0.
  - ref_out=0, shift_out=0.
  - sync flops and edge-history flops=1 (button released).
  - both lockout counters=0.
- Reset asserted mid-operation: all of the above take effect on the next clk edge; pending presses are discarded.
- Period counter cnt:
  - increments every cycle from 0 to P-1, then wraps to 0.
- ref_out:
  - registered from (cnt < HALF_PERIOD), so it lags cnt by 1 cycle.
  - After reset release: 1 for HALF_PERIOD cycles, then 0 for HALF_PERIOD cycles, repeating.
- shift_out:
  - registered from (pos < HALF_PERIOD), where pos = (cnt - phase) mod P.
  - pos is computed without signed arithmetic: pos = cnt - phase if cnt >= phase, otherwise cnt + P - phase.
  - Result: shift_out is ref_out delayed by exactly phase cycles.
- Buttons:
  - each button passes through a 2-flop synchronizer, then a falling-edge detector on the synchronized value.
  - An edge is detected 3 clk cycles after the pin falls.
- Debounce:
  - an edge is accepted only if that button's lockout counter is 0.
  - On acceptance the lockout counter loads DEBOUNCE_CYCLES and counts down to 0.
  - Edges arriving while the counter is nonzero are ignored.
  - The two buttons have independent lockouts.
- phase_next update:
  - accepted inc: phase_next = (phase_next + STEP) mod P.
  - accepted dec: phase_next = (phase_next - STEP) mod P.
  - Wrap is computed explicitly; never rely on power-of-2 overflow.
- Simultaneous accepted inc and dec in the same cycle:
  - phase_next is unchanged.
  - Both lockouts still load DEBOUNCE_CYCLES.
- Glitch-free apply:
  - phase <= phase_next only on the cycle where cnt == P-1.
  - The offset therefore never changes mid-period.
  - Several presses within one period collapse into their net result at that wrap.
- phase output reflects the applied value, not phase_next.

Test Plan (HALF_PERIOD=4, P=8, STEP=1, DEBOUNCE_CYCLES=8, CNT_W=3):
- Hold rst=1 for 3 cycles -> ref_out=0, shift_out=0, phase=0. After release: ref_out and shift_out are identical, 4 cycles high then 4 cycles low.
- Single inc press (pin low 20 cycles) -> phase becomes 1 at the next cnt=7 wrap. shift_out then rises exactly 1 cycle after each ref_out rise. No runt pulse on either output.
- Dec press from phase=0 -> phase becomes 7. shift_out rises 7 cycles after ref_out, i.e. 1 cycle before it.
- Bouncing inc (3 falling edges within 6 cycles) -> phase increments by 1 only. A fourth edge 10 cycles after the first accepted edge increments it again.
- inc and dec pins falling in the same cycle -> phase unchanged. 8 separate inc presses from phase=0 -> phase wraps to 0.
- Set phase=5, then assert rst for 1 cycle mid-period -> next cycle cnt=0, phase=0, ref_out=0, shift_out=0; waves then restart in phase.
